conv_mac_sequencer: RTL and testbench
=====================================

// Module: conv_mac_sequencer
// PURPOSE
//  Sequences one KSIZE x KSIZE convolution window on the CNN datapath: fetches input-tile and
//  weight words, multiply-accumulates them, and returns one signed result per window.
//  Borrows the shared ALU slot from the core: drives ALU control code 3'b111 (MAC) and stalls
//  the pipeline while streaming. Sits between the core's CNN issue logic and the feature/weight
//  buffers; returns results through a valid/ready handshake.
// PARAMETERS
//  DATA_W   32  width of input and weight words (signed two's complement)
//  ACC_W    32  accumulator/result width
//  ADDR_W   8   buffer address width
//  KSIZE    3   kernel edge length (>=1); window = KSIZE*KSIZE taps
// PORTS
//  clk           in   1       single clock; all state updates on rising edge
//  rst           in   1       synchronous reset, active-low
//  start         in   1       request one window; sampled only in IDLE
//  base_in_addr  in   ADDR_W  input-tile address of window top-left tap
//  base_w_addr   in   ADDR_W  address of first weight
//  row_stride    in   ADDR_W  input-tile address step between window rows
//  rd_en         out  1       read strobe to both buffers
//  in_addr       out  ADDR_W  input-tile read address
//  w_addr        out  ADDR_W  weight read address
//  in_data       in   DATA_W  input word, valid exactly 1 cycle after rd_en
//  w_data        in   DATA_W  weight word, valid exactly 1 cycle after rd_en
//  alu_ctrl      out  3       3'b111 while busy, else 3'b000
//  stall_req     out  1       pipeline stall request; equal to busy
//  busy          out  1       1 in ISSUE/DRAIN/DONE
//  result        out  ACC_W   accumulated window sum; stable while result_valid
//  result_valid  out  1       result available
//  result_ready  in   1       consumer accepts result
// BEHAVIOUR
//  Reset (rst==0 at edge): state IDLE; all counters and accumulator cleared; rd_en, busy,
//   stall_req and result_valid are 0; result is 0; alu_ctrl is 3'b000; in_addr/w_addr are 0.
//   Reset mid-window aborts the window with no result produced.
//  FSM: IDLE -start-> ISSUE -(last tap issued)-> DRAIN -> DONE -(result_valid&result_ready)-> IDLE.
//  IDLE: on start, latch base/stride, clear acc, row=col=idx=0. In any other state, start is ignored.
//  ISSUE: rd_en=1 for exactly KSIZE*KSIZE consecutive cycles.
//   Addresses: in_addr = base_in + row*row_stride + col; w_addr = base_w + idx.
//   Address arithmetic wraps modulo 2^ADDR_W.
//   Tap order: col advances fastest; col wraps to 0 at KSIZE-1 and row++; idx increments every tap.
//  Data path: dv_q <= rd_en. When dv_q=1: acc <= acc + sext(in_data)*sext(w_data).
//   The product is truncated to ACC_W and the sum wraps modulo 2^ACC_W (no saturation, no flag).
//  DRAIN: one cycle with rd_en=0; the last tap is accumulated at the end of this cycle.
//  DONE: result_valid=1; result=acc is held. Stay in DONE while result_ready=0.
//   On result_valid & result_ready, go to IDLE; a start in that same cycle is ignored.
//  Latency: start high in cycle c0 -> rd_en high in c1..c(K^2) -> DRAIN in c(K^2+1)
//   -> result_valid high from c(K^2+2). For KSIZE=3, result_valid is first high in c11.
//  Throughput: one window per K^2+3 cycles minimum (includes one IDLE cycle).
//  KSIZE=1: a single ISSUE cycle, then DRAIN, then DONE.
// STRUCTURE
//  cnn_pkg (shared): ALU_CTRL_ADD=3'b000, ALU_CTRL_SUB=3'b001, ALU_CTRL_MAC=3'b111,
//   seq_state_t {IDLE,ISSUE,DRAIN,DONE}.
//  Sub-module mac_accumulator: holds acc plus its clear/enable/sign-extend/multiply logic
//   (DATA_W, ACC_W). The FSM, counters and address generation stay in the top module.
// TESTING
//  1. KSIZE=3, all in_data=1, all w_data=1, result_ready=1 -> result=9, result_valid first
//     high 11 cycles after start, held high for 1 cycle.
//  2. base_in=0x10, row_stride=8, base_w=0x40 -> in_addr sequence 10,11,12,18,19,1A,20,21,22;
//     w_addr sequence 40..48; rd_en high for exactly 9 cycles.
//  3. in_data=-2 on all taps, w_data=tap index 0..8 -> result=-72 (0xFFFFFFB8).
//  4. Hold result_ready=0 for 5 cycles in DONE -> result and result_valid stable; start pulses
//     ignored; on acceptance return to IDLE with busy=0.
//  5. Drive rst=0 at ISSUE tap 4 -> next cycle IDLE, rd_en=0, acc=0, alu_ctrl=000, and no
//     result_valid. A fresh start afterwards gives the correct result.
//  6. base_in=0xFE, row_stride=1, KSIZE=2 -> in_addr sequence FE,FF,FF,00 (wrap-around);
//     each product 0x10000*0x10000 truncates to 0, so result=0 (0x00000000) with ACC_W=32.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: ALU control codes and the window sequencer states.
package cnn_pkg;

  localparam logic [2:0] ALU_CTRL_ADD = 3'b000;
  localparam logic [2:0] ALU_CTRL_SUB = 3'b001;
  localparam logic [2:0] ALU_CTRL_MAC = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/mac_accumulator.sv
// Signed multiply-accumulate register. Operands are sign-extended (or truncated) to the
// accumulator width before multiplying, so the product and sum both wrap modulo 2^ACC_W.
module mac_accumulator #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] w_data,
  output logic [ACC_W-1:0]  acc
);

  logic [ACC_W-1:0] inExt;
  logic [ACC_W-1:0] wExt;
  logic [ACC_W-1:0] product;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  // Only the low ACC_W bits of the product are kept, so operands wider than the
  // accumulator can be cut down before multiplying without changing the result.
  generate
    if (DATA_W < ACC_W) begin : g_extend
      assign inExt = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
      assign wExt  = {{(ACC_W-DATA_W){w_data[DATA_W-1]}}, w_data};
    end else begin : g_truncate
      assign inExt = in_data[ACC_W-1:0];
      assign wExt  = w_data[ACC_W-1:0];
    end
  endgenerate

  // Next accumulator value: clear at window start, add one product per valid tap.
  always_comb begin
    product = inExt * wExt;
    acc_d   = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + product;
    end
  end

  // Accumulator register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_mac_sequencer.sv
// Sequences one KSIZE x KSIZE convolution window: issues buffer reads tap by tap, feeds the
// returning words into the MAC accumulator, and hands back the window sum over valid/ready.
// While a window is in flight it owns the shared ALU slot (MAC code) and stalls the core.
module conv_mac_sequencer
  import cnn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 8,
  parameter int KSIZE  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_in_addr,
  input  logic [ADDR_W-1:0] base_w_addr,
  input  logic [ADDR_W-1:0] row_stride,
  output logic              rd_en,
  output logic [ADDR_W-1:0] in_addr,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] w_data,
  output logic [2:0]        alu_ctrl,
  output logic              stall_req,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int TAPS  = KSIZE * KSIZE;
  localparam int COL_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(KSIZE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAPS - 1);

  seq_state_t        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] rowOff_q, rowOff_d;
  logic [ADDR_W-1:0] baseIn_q, baseIn_d;
  logic [ADDR_W-1:0] baseW_q, baseW_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic              dv_q;
  logic              accClear;
  logic [ACC_W-1:0]  accValue;

  // Next-state, counter and output decode. The row offset is kept as a running sum of the
  // stride, which gives row*row_stride without a multiplier.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    idx_d        = idx_q;
    rowOff_d     = rowOff_q;
    baseIn_d     = baseIn_q;
    baseW_d      = baseW_q;
    stride_d     = stride_q;
    accClear     = 1'b0;
    rd_en        = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    in_addr      = '0;
    w_addr       = '0;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d  = ISSUE;
          baseIn_d = base_in_addr;
          baseW_d  = base_w_addr;
          stride_d = row_stride;
          col_d    = '0;
          idx_d    = '0;
          rowOff_d = '0;
          accClear = 1'b1;
        end
      end
      ISSUE: begin
        rd_en   = 1'b1;
        in_addr = baseIn_q + rowOff_q + ADDR_W'(col_q);
        w_addr  = baseW_q + ADDR_W'(idx_q);
        if (idx_q == IDX_LAST) begin
          state_d = DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (col_q == COL_LAST) begin
            col_d    = '0;
            rowOff_d = rowOff_q + stride_q;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall_req = busy;
  assign alu_ctrl  = busy ? ALU_CTRL_MAC : ALU_CTRL_ADD;
  assign result    = accValue;

  // State, counters and latched window parameters; reset abandons any window in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      idx_q    <= '0;
      rowOff_q <= '0;
      baseIn_q <= '0;
      baseW_q  <= '0;
      stride_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      idx_q    <= idx_d;
      rowOff_q <= rowOff_d;
      baseIn_q <= baseIn_d;
      baseW_q  <= baseW_d;
      stride_q <= stride_d;
      dv_q     <= rd_en;
    end
  end

  mac_accumulator #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (accClear),
    .en     (dv_q),
    .in_data(in_data),
    .w_data (w_data),
    .acc    (accValue)
  );

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer: a KSIZE=3 instance covers the main scenarios and a
// KSIZE=2 instance covers address wrap-around and product truncation.
module tb_conv_mac_sequencer;

  logic        clk;
  logic        rst;

  logic        start, rdEn, resultValid, resultReady, busy, stallReq;
  logic [7:0]  baseIn, baseW, stride, inAddr, wAddr;
  logic [31:0] inData, wData, result;
  logic [2:0]  aluCtrl;

  logic        start2, rdEn2, resultValid2, resultReady2, busy2, stallReq2;
  logic [7:0]  baseIn2, baseW2, stride2, inAddr2, wAddr2;
  logic [31:0] inData2, wData2, result2;
  logic [2:0]  aluCtrl2;

  logic [31:0] inMem [0:255];
  logic [31:0] wMem  [0:255];

  int checks;
  int failures;

  conv_mac_sequencer #(.DATA_W(32), .ACC_W(32), .ADDR_W(8), .KSIZE(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_in_addr(baseIn), .base_w_addr(baseW), .row_stride(stride),
    .rd_en(rdEn), .in_addr(inAddr), .w_addr(wAddr),
    .in_data(inData), .w_data(wData),
    .alu_ctrl(aluCtrl), .stall_req(stallReq), .busy(busy),
    .result(result), .result_valid(resultValid), .result_ready(resultReady)
  );

  conv_mac_sequencer #(.DATA_W(32), .ACC_W(32), .ADDR_W(8), .KSIZE(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .base_in_addr(baseIn2), .base_w_addr(baseW2), .row_stride(stride2),
    .rd_en(rdEn2), .in_addr(inAddr2), .w_addr(wAddr2),
    .in_data(inData2), .w_data(wData2),
    .alu_ctrl(aluCtrl2), .stall_req(stallReq2), .busy(busy2),
    .result(result2), .result_valid(resultValid2), .result_ready(resultReady2)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer models: read data appears one cycle after the strobe.
  always @(posedge clk) begin
    if (rdEn) begin
      inData <= inMem[inAddr];
      wData  <= wMem[wAddr];
    end
    if (rdEn2) begin
      inData2 <= inMem[inAddr2];
      wData2  <= wMem[wAddr2];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic fillMem(input logic [31:0] inVal, input logic [31:0] wVal);
    for (int i = 0; i < 256; i++) begin
      inMem[i] = inVal;
      wMem[i]  = wVal;
    end
  endtask

  // Outputs of both instances while reset is held.
  task automatic test_reset;
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if ({rdEn, busy, stallReq, resultValid} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {rdEn, busy, stallReq, resultValid});
    end
    checks++;
    if (result !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_result: got %h expected 00000000", result);
    end
    checks++;
    if (aluCtrl !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_alu_ctrl: got %b expected 000", aluCtrl);
    end
    checks++;
    if ({inAddr, wAddr} !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_addr: got %h/%h expected 00/00", inAddr, wAddr);
    end
    checks++;
    if ({busy2, resultValid2, result2} !== 34'h0) begin
      failures++;
      $display("[TB] FAIL reset_k2: got busy=%b valid=%b result=%h expected all 0", busy2, resultValid2, result2);
    end
    rst = 1'b1;
    step();
  endtask

  // All-ones window: result 9, valid first in cycle 11 and for a single cycle.
  task automatic test_single_window;
    int firstValid;
    int validCount;
    logic [31:0] got;
    fillMem(32'd1, 32'd1);
    baseIn = 8'h00; stride = 8'h03; baseW = 8'h00; resultReady = 1'b1;
    firstValid = -1; validCount = 0; got = 32'hDEADBEEF;
    start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      start = 1'b0;
      if (resultValid) begin
        if (firstValid < 0) firstValid = cyc;
        validCount++;
        got = result;
      end
    end
    checks++;
    if (firstValid != 11) begin
      failures++;
      $display("[TB] FAIL latency: got cycle %0d expected 11", firstValid);
    end
    checks++;
    if (validCount != 1) begin
      failures++;
      $display("[TB] FAIL valid_width: got %0d cycles expected 1", validCount);
    end
    checks++;
    if (got !== 32'd9) begin
      failures++;
      $display("[TB] FAIL ones_result: got %h expected 00000009", got);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_after_accept: got busy=%b expected 0", busy);
    end
  endtask

  // Address sequence with a row stride of 8, plus control outputs while issuing.
  task automatic test_addresses;
    logic [7:0] expIn [9];
    int n;
    int firstRd;
    int lastRd;
    expIn = '{8'h10, 8'h11, 8'h12, 8'h18, 8'h19, 8'h1A, 8'h20, 8'h21, 8'h22};
    fillMem(32'd0, 32'd0);
    baseIn = 8'h10; stride = 8'h08; baseW = 8'h40; resultReady = 1'b1;
    n = 0; firstRd = -1; lastRd = -1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      start = 1'b0;
      if (cyc == 1) begin
        checks++;
        if ({aluCtrl, stallReq, busy} !== 5'b11111) begin
          failures++;
          $display("[TB] FAIL issue_ctrl: got alu=%b stall=%b busy=%b expected 111/1/1", aluCtrl, stallReq, busy);
        end
      end
      if (rdEn) begin
        if (firstRd < 0) firstRd = cyc;
        lastRd = cyc;
        if (n < 9) begin
          checks++;
          if (inAddr !== expIn[n]) begin
            failures++;
            $display("[TB] FAIL in_addr[%0d]: got %h expected %h", n, inAddr, expIn[n]);
          end
          checks++;
          if (wAddr !== 8'h40 + 8'(n)) begin
            failures++;
            $display("[TB] FAIL w_addr[%0d]: got %h expected %h", n, wAddr, 8'h40 + 8'(n));
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 9 || firstRd != 1 || lastRd != 9) begin
      failures++;
      $display("[TB] FAIL rd_en_span: got %0d cycles (%0d..%0d) expected 9 (1..9)", n, firstRd, lastRd);
    end
  endtask

  // Signed data: -2 times weights 0..8 sums to -72.
  task automatic test_signed;
    logic [31:0] got;
    fillMem(32'hFFFFFFFE, 32'd0);
    for (int i = 0; i < 9; i++) wMem[8'h40 + i] = 32'(i);
    baseIn = 8'h10; stride = 8'h08; baseW = 8'h40; resultReady = 1'b1;
    got = 32'hDEADBEEF;
    start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      start = 1'b0;
      if (resultValid) got = result;
    end
    checks++;
    if (got !== 32'hFFFFFFB8) begin
      failures++;
      $display("[TB] FAIL signed_result: got %h expected FFFFFFB8", got);
    end
  endtask

  // Result held under back-pressure; start ignored in DONE and on the accepting cycle.
  task automatic test_back_to_back;
    int waitCyc;
    fillMem(32'd3, 32'd1);
    baseIn = 8'h00; stride = 8'h03; baseW = 8'h00; resultReady = 1'b0;
    start = 1'b1;
    waitCyc = 0;
    do begin
      step();
      start = 1'b0;
      waitCyc++;
    end while (!resultValid && waitCyc < 20);
    checks++;
    if (resultValid !== 1'b1 || waitCyc != 11) begin
      failures++;
      $display("[TB] FAIL bp_reach_done: got valid=%b at cycle %0d expected 1 at 11", resultValid, waitCyc);
    end
    for (int k = 0; k < 5; k++) begin
      start = k[0];
      step();
      checks++;
      if ({resultValid, busy} !== 2'b11 || result !== 32'd27) begin
        failures++;
        $display("[TB] FAIL bp_hold[%0d]: got valid=%b busy=%b result=%h expected 1/1/0000001B", k, resultValid, busy, result);
      end
    end
    start = 1'b1;
    resultReady = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, resultValid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL bp_accept: got busy=%b valid=%b expected 0/0", busy, resultValid);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL accept_start_ignored: got busy=%b expected 0", busy);
    end
  endtask

  // Reset at tap 4 aborts the window; a fresh window then completes correctly.
  task automatic test_reset_abort;
    int strayValid;
    logic [31:0] got;
    fillMem(32'd1, 32'd1);
    baseIn = 8'h00; stride = 8'h03; baseW = 8'h00; resultReady = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    checks++;
    if (rdEn !== 1'b1 || wAddr !== 8'h04) begin
      failures++;
      $display("[TB] FAIL abort_at_tap4: got rd_en=%b w_addr=%h expected 1/04", rdEn, wAddr);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({rdEn, busy, resultValid} !== 3'b000 || aluCtrl !== 3'b000 || result !== 32'h0) begin
      failures++;
      $display("[TB] FAIL abort_state: got rd=%b busy=%b valid=%b alu=%b acc=%h expected 0/0/0/000/0",
               rdEn, busy, resultValid, aluCtrl, result);
    end
    rst = 1'b1;
    strayValid = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      step();
      if (resultValid || busy) strayValid++;
    end
    checks++;
    if (strayValid != 0) begin
      failures++;
      $display("[TB] FAIL abort_no_result: got %0d active cycles expected 0", strayValid);
    end
    got = 32'hDEADBEEF;
    start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      start = 1'b0;
      if (resultValid) got = result;
    end
    checks++;
    if (got !== 32'd9) begin
      failures++;
      $display("[TB] FAIL after_abort_result: got %h expected 00000009", got);
    end
  endtask

  // KSIZE=2 window whose addresses wrap past FF; every product truncates to zero.
  task automatic test_ksize2_wrap;
    logic [7:0] expIn [4];
    int n;
    int firstValid;
    logic [31:0] got;
    expIn = '{8'hFE, 8'hFF, 8'hFF, 8'h00};
    fillMem(32'd1, 32'h00010000);
    inMem[8'hFE] = 32'h00010000;
    inMem[8'hFF] = 32'h00010000;
    inMem[8'h00] = 32'h00010000;
    baseIn2 = 8'hFE; stride2 = 8'h01; baseW2 = 8'h80; resultReady2 = 1'b1;
    n = 0; firstValid = -1; got = 32'hDEADBEEF;
    start2 = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      start2 = 1'b0;
      if (rdEn2) begin
        if (n < 4) begin
          checks++;
          if (inAddr2 !== expIn[n]) begin
            failures++;
            $display("[TB] FAIL k2_in_addr[%0d]: got %h expected %h", n, inAddr2, expIn[n]);
          end
        end
        n++;
      end
      if (resultValid2) begin
        if (firstValid < 0) firstValid = cyc;
        got = result2;
      end
    end
    checks++;
    if (n != 4 || firstValid != 6) begin
      failures++;
      $display("[TB] FAIL k2_timing: got %0d reads, valid at %0d expected 4 reads, valid at 6", n, firstValid);
    end
    checks++;
    if (got !== 32'h0) begin
      failures++;
      $display("[TB] FAIL k2_result: got %h expected 00000000", got);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    start = 1'b0; baseIn = '0; baseW = '0; stride = '0; resultReady = 1'b0;
    start2 = 1'b0; baseIn2 = '0; baseW2 = '0; stride2 = '0; resultReady2 = 1'b0;
    inData = '0; wData = '0; inData2 = '0; wData2 = '0;
    fillMem(32'd0, 32'd0);
    #1;
    $display("[TB] starting conv_mac_sequencer bench");
    test_reset();
    test_single_window();
    test_addresses();
    test_signed();
    test_back_to_back();
    test_reset_abort();
    test_ksize2_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
